// File: rtl/disparador_pkg.sv
// disparador_pkg: shared definitions for the ultrasonic trigger/echo timer.
//   state_e              - FSM state encoding
//   TRIG_CYCLES etc.     - default timing constants (cycles at 1 MHz)
//   param_ok()           - elaboration-time range check for timing parameters
package disparador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_WAIT_FALL = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_e;

  localparam int TRIG_CYCLES    = 10;
  localparam int ECHO_TIMEOUT   = 38000;
  localparam int HOLDOFF_CYCLES = 60000;
  localparam int CNT_W          = 16;

  // True when value is nonzero and representable in an unsigned width-bit counter.
  function automatic bit param_ok(input int value, input int width);
    return (value > 0) && (width > 0) && ((width >= 31) || (value < (1 << width)));
  endfunction

endpackage

// File: rtl/sincronizador.sv
// sincronizador: two-flop synchronizer for a single asynchronous bit.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, both stages clear to 0
//   d     - asynchronous input
//   q     - synchronized output (two clk edges of latency)
module sincronizador (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/disparador.sv
// disparador: ultrasonic range sensor controller. Issues a TRIGGER pulse,
// measures the width of the returned ECHO pulse in clock cycles, then waits
// a quiet holdoff before the next measurement.
//   CLKOUT  - clock, rising edge
//   reset   - asynchronous active-low reset
//   ENABLE  - level, permits new measurement cycles
//   ECHO    - asynchronous echo from the sensor
//   TRIGGER - trigger pulse, TRIG_CYCLES long
//   BUSY    - high whenever the FSM is not idle
//   DONE    - one-cycle pulse when WIDTH is updated
//   TIMEOUT - one-cycle pulse when a measurement is abandoned
//   WIDTH   - last valid echo width in cycles
module disparador #(
  parameter int TRIG_CYCLES    = disparador_pkg::TRIG_CYCLES,
  parameter int ECHO_TIMEOUT   = disparador_pkg::ECHO_TIMEOUT,
  parameter int HOLDOFF_CYCLES = disparador_pkg::HOLDOFF_CYCLES,
  parameter int CNT_W          = disparador_pkg::CNT_W
) (
  input  logic             CLKOUT,
  input  logic             reset,
  input  logic             ENABLE,
  input  logic             ECHO,
  output logic             TRIGGER,
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] WIDTH
);
  import disparador_pkg::*;

  if (!param_ok(TRIG_CYCLES, CNT_W)) begin : g_bad_trig
    $error("TRIG_CYCLES must be nonzero and fit in CNT_W bits");
  end
  if (!param_ok(ECHO_TIMEOUT, CNT_W)) begin : g_bad_echo
    $error("ECHO_TIMEOUT must be nonzero and fit in CNT_W bits");
  end
  if (!param_ok(HOLDOFF_CYCLES, CNT_W)) begin : g_bad_hold
    $error("HOLDOFF_CYCLES must be nonzero and fit in CNT_W bits");
  end

  // Terminal counts. TRIG/WAIT_RISE/HOLDOFF start at 0, so the last cycle of
  // an N-cycle interval sees N-1. WAIT_FALL starts at 1 and counts high cycles.
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FALL_MAX  = CNT_W'(ECHO_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             enable_q;
  logic             echo_s;

  sincronizador u_sync (
    .clk   (CLKOUT),
    .rst_n (reset),
    .d     (ECHO),
    .q     (echo_s)
  );

  // FSM: next state and registered pulse/width outputs.
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // ENABLE is registered once so that the first trigger after reset
        // release needs two edges with ENABLE high.
        if (enable_q) state_d = ST_TRIG;
      end
      ST_TRIG: begin
        if (cnt_q >= TRIG_LAST) state_d = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (echo_s) begin
          state_d = ST_WAIT_FALL;
        end else if (cnt_q >= RISE_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_HOLDOFF;
        end
      end
      ST_WAIT_FALL: begin
        if (!echo_s) begin
          width_d = cnt_q;
          done_d  = 1'b1;
          state_d = ST_HOLDOFF;
        end else if (cnt_q >= FALL_MAX) begin
          timeout_d = 1'b1;
          state_d   = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        // A stuck echo keeps us here past the holdoff until it clears.
        if ((cnt_q >= HOLD_LAST) && !echo_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shared counter: cleared on every state change (preset to 1 entering
  // WAIT_FALL, since the rise cycle is the first high cycle), otherwise a
  // saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = (state_d == ST_WAIT_FALL) ? CNT_W'(1) : '0;
    end else if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLKOUT or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      width_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      enable_q  <= ENABLE;
    end
  end

  assign TRIGGER = (state_q == ST_TRIG);
  assign BUSY    = (state_q != ST_IDLE);
  assign DONE    = done_q;
  assign TIMEOUT = timeout_q;
  assign WIDTH   = width_q;

endmodule

// File: tb/tb_disparador.sv
module tb_disparador;

  localparam int TC = 5;
  localparam int ET = 100;
  localparam int HC = 20;
  localparam int W  = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         echo = 1'b0;
  logic         trigger, busy, done, tmo;
  logic [W-1:0] width;

  disparador #(
    .TRIG_CYCLES    (TC),
    .ECHO_TIMEOUT   (ET),
    .HOLDOFF_CYCLES (HC),
    .CNT_W          (W)
  ) dut (
    .CLKOUT  (clk),
    .reset   (rst_n),
    .ENABLE  (enable),
    .ECHO    (echo),
    .TRIGGER (trigger),
    .BUSY    (busy),
    .DONE    (done),
    .TIMEOUT (tmo),
    .WIDTH   (width)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         is_to;
    logic [W-1:0] width;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   trig_len = 0;
  int   trig_rises = 0;
  logic trig_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_trig(input logic lvl, input int lim, input string name);
    int k = 0;
    while (trigger !== lvl && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(trigger === lvl), 32'd1);
  endtask

  task automatic wait_sb_empty(input int lim, input string name);
    int k = 0;
    while (sb.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic push_exp(input logic is_to, input logic [W-1:0] w);
    exp_t e;
    e.is_to = is_to;
    e.width = w;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every DONE/TIMEOUT pulse must match the next expectation.
  always @(negedge clk) begin
    if (done || tmo) begin
      check("done_timeout_exclusive", 32'(done && tmo), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got done=%0d timeout=%0d expected none", done, tmo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_is_timeout", 32'(tmo), 32'(e.is_to));
        check("event_width", 32'(width), 32'(e.width));
      end
    end
  end

  // Trigger monitor: every completed pulse is exactly TC cycles long.
  always @(negedge clk) begin
    if (trigger && !trig_prev) trig_rises++;
    if (trigger) begin
      trig_len++;
    end else if (trig_len != 0) begin
      check("trigger_len", 32'(trig_len), 32'(TC));
      trig_len = 0;
    end
    trig_prev = trigger;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int r;

    // Reset state
    cyc(4);
    check("rst_trigger", 32'(trigger), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(tmo), 0);
    check("rst_width", 32'(width), 0);
    rst_n = 1'b1;
    cyc(3);
    check("idle_no_enable_busy", 32'(busy), 0);

    // First trigger not before the second edge with ENABLE high
    enable = 1'b1;
    @(negedge clk);
    check("trig_not_on_first_edge", 32'(trigger), 0);

    // Nominal: 25-cycle echo 10 cycles after trigger falls
    wait_trig(1'b1, 10, "nom_trig_rise");
    wait_trig(1'b0, 10, "nom_trig_fall");
    cyc(10);
    push_exp(1'b0, 16'd25);
    echo = 1'b1;
    cyc(25);
    echo = 1'b0;
    wait_sb_empty(50, "nom_done_seen");
    check("nom_width_held", 32'(width), 25);

    // Missing echo after a fresh reset
    cyc(1);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    wait_trig(1'b1, 10, "miss_trig_rise");
    wait_trig(1'b0, 10, "miss_trig_fall");
    push_exp(1'b1, 16'd0);
    k = 0;
    while (!tmo && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("miss_timeout_delay", 32'(k), 32'(ET));
    k = 0;
    while (!trigger && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("miss_holdoff_gap", 32'(k), 32'(HC + 1));
    check("miss_width_zero", 32'(width), 0);

    // Stuck echo: timeout at count ET, holdoff held until echo falls
    wait_trig(1'b0, 10, "stuck_trig_fall");
    cyc(1);
    push_exp(1'b1, 16'd0);
    r = trig_rises;
    echo = 1'b1;
    cyc(299);
    check("stuck_timeout_seen", 32'(sb.size()), 0);
    check("stuck_busy_held", 32'(busy), 1);
    check("stuck_no_retrigger", 32'(trig_rises), 32'(r));
    echo = 1'b0;

    // Early echo during TRIG is ignored
    wait_trig(1'b1, 20, "early_trig_rise");
    cyc(1);
    echo = 1'b1;
    cyc(2);
    echo = 1'b0;
    wait_trig(1'b0, 10, "early_trig_fall");
    check("early_width_unchanged", 32'(width), 0);
    check("early_no_event", 32'(done || tmo), 0);
    cyc(5);
    push_exp(1'b0, 16'd7);
    echo = 1'b1;
    cyc(7);
    echo = 1'b0;
    wait_sb_empty(50, "early_done_seen");

    // ENABLE dropped during WAIT_FALL: measurement completes, then idle
    wait_trig(1'b1, 40, "en_trig_rise");
    wait_trig(1'b0, 10, "en_trig_fall");
    cyc(3);
    push_exp(1'b0, 16'd12);
    echo = 1'b1;
    cyc(5);
    enable = 1'b0;
    cyc(7);
    echo = 1'b0;
    wait_sb_empty(50, "en_done_seen");
    r = trig_rises;
    cyc(40);
    check("en_idle_busy", 32'(busy), 0);
    check("en_no_retrigger", 32'(trig_rises), 32'(r));

    // Reset mid-WAIT_FALL
    enable = 1'b1;
    wait_trig(1'b1, 10, "rstm_trig_rise");
    wait_trig(1'b0, 10, "rstm_trig_fall");
    cyc(2);
    echo = 1'b1;
    cyc(8);
    check("rstm_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rstm_trigger", 32'(trigger), 0);
    check("rstm_busy", 32'(busy), 0);
    check("rstm_done", 32'(done), 0);
    check("rstm_timeout", 32'(tmo), 0);
    check("rstm_width", 32'(width), 0);
    cyc(3);
    enable = 1'b0;
    rst_n = 1'b1;
    cyc(5);
    echo = 1'b0;
    cyc(30);
    check("rstm_idle_after", 32'(busy), 0);
    check("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disparador.md
DISPARADOR -- requirements
Module: disparador

Interface
REQ-001 Parameter TRIG_CYCLES, default 10: TRIGGER high time in clock cycles (10 us at 1 MHz).
REQ-002 Parameter ECHO_TIMEOUT, default 38000: maximum wait for an echo edge, in cycles.
REQ-003 Parameter HOLDOFF_CYCLES, default 60000: quiet time between measurements, in cycles.
REQ-004 Parameter CNT_W, default 16: width of the internal counters and of WIDTH.
REQ-005 Port CLKOUT, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port ENABLE, input, 1 bit: level; a high value permits new measurement cycles.
REQ-008 Port ECHO, input, 1 bit: asynchronous echo pulse from the sensor.
REQ-009 Port TRIGGER, output, 1 bit: trigger pulse to the sensor.
REQ-010 Port BUSY, output, 1 bit: high in every state except IDLE.
REQ-011 Port DONE, output, 1 bit: one-cycle pulse when a valid WIDTH has been latched.
REQ-012 Port TIMEOUT, output, 1 bit: one-cycle pulse when a measurement is abandoned.
REQ-013 Port WIDTH, output, CNT_W bits: last valid echo width, in cycles.

Function
REQ-014 ECHO SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized signal (ECHO_S).
REQ-015 FSM states SHALL be IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF.
REQ-016 IDLE: if ENABLE=1 on a clock edge, go to TRIG and clear the counter.
REQ-017 TRIG: TRIGGER=1 for exactly TRIG_CYCLES consecutive cycles, then go to WAIT_RISE with TRIGGER=0.
REQ-018 WAIT_RISE: on ECHO_S=1, go to WAIT_FALL with the width counter set to 1.
REQ-019 WAIT_RISE: after ECHO_TIMEOUT cycles with no rise, pulse TIMEOUT for 1 cycle and go to HOLDOFF; WIDTH is unchanged.
REQ-020 WAIT_FALL: the counter increments each cycle while ECHO_S=1.
REQ-021 WAIT_FALL, on ECHO_S=0: latch WIDTH = count of high cycles (equal to the raw ECHO pulse width); assert DONE in the cycle WIDTH updates; go to HOLDOFF.
REQ-022 WAIT_FALL: if the count reaches ECHO_TIMEOUT, pulse TIMEOUT, leave WIDTH unchanged, go to HOLDOFF.
REQ-023 HOLDOFF: count HOLDOFF_CYCLES cycles; exit to IDLE only when the count is complete and ECHO_S=0; otherwise stay.
REQ-024 ENABLE falling mid-cycle: the current cycle completes normally; the FSM stops in IDLE.
REQ-025 ECHO activity in IDLE, TRIG or HOLDOFF SHALL be ignored and SHALL NOT change WIDTH.
REQ-026 DONE and TIMEOUT SHALL never be asserted in the same cycle.
REQ-027 All counters SHALL be CNT_W bits, unsigned, saturating, and never wrap.
REQ-028 Elaboration SHALL fail if any timing parameter is 0 or does not fit in CNT_W bits.

Reset
REQ-029 With reset=0, asynchronously: state=IDLE, TRIGGER=0, BUSY=0, DONE=0, TIMEOUT=0, WIDTH=0, counters=0, synchronizer=0.
REQ-030 Reset asserted mid-measurement aborts immediately; no DONE or TIMEOUT pulse is produced.
REQ-031 After reset release, the first TRIGGER rises no earlier than the second CLKOUT edge with ENABLE=1.

Structure
REQ-032 Package disparador_pkg SHALL hold the state enum and the default constants TRIG_CYCLES, ECHO_TIMEOUT, HOLDOFF_CYCLES and CNT_W.
REQ-033 The 2-flop synchronizer SHALL be a separate sub-module, sincronizador, with reset to 0.
REQ-034 Everything else SHALL be one FSM process plus one counter process; no other sub-modules.

Verification (TRIG_CYCLES=5, ECHO_TIMEOUT=100, HOLDOFF_CYCLES=20)
REQ-035 Nominal: reset low for 4 cycles, ENABLE=1, ECHO high for 25 cycles starting 10 cycles after TRIGGER falls -> TRIGGER high for exactly 5 cycles; WIDTH=25; one DONE pulse.
REQ-036 Missing echo: ECHO held at 0 -> TIMEOUT pulses 100 cycles after TRIGGER falls; WIDTH stays 0; the next TRIGGER follows the 20-cycle holdoff.
REQ-037 Stuck echo: ECHO high for 300 cycles -> TIMEOUT pulses when the count reaches 100; HOLDOFF holds until ECHO falls; no DONE.
REQ-038 Early echo: ECHO pulse during TRIG -> ignored; WIDTH unchanged; FSM waits for the next rise in WAIT_RISE.
REQ-039 ENABLE dropped during WAIT_FALL -> the measurement completes with DONE, then IDLE with BUSY=0; no further TRIGGER.
REQ-040 Reset asserted mid-WAIT_FALL -> all outputs are 0 immediately; no DONE or TIMEOUT pulse afterwards.
